control_unit: RTL
=================

# control_unit

Multi-cycle Moore controller that sequences the processor datapath. It takes the decoded instruction and ALU flags from the datapath and drives the PC, IR, address mux, register-file write, ALU operation and RAM write strobe. Together with the datapath it forms the CPU top level that connects to the 32-word by 16-bit RAM.

## Interface
- No parameters; all encodings come from `cpu_pkg`.
- `clk`: in, 1. Single system clock; all state updates on the rising edge.
- `rst_n`: in, 1. Asynchronous, active-low reset.
- `decoded_instruction`: in, 5. `decoded_instruction_type` value from the datapath.
- `zero`, `neg`, `unsigned_overflow`, `signed_overflow`: in, 1 each. Registered flags from the datapath.
- `branch`: out, 1. PC loads the IR address field instead of PC+1.
- `pc_enable`: out, 1. PC register update.
- `ir_enable`: out, 1. IR loads `data_in`.
- `addr_sel`: out, 1. RAM address select: 0 = PC, 1 = IR address field.
- `c_sel`: out, 1. Register write source: 0 = ALU, 1 = RAM `data_in`.
- `white_reg_enable`: out, 1. Register-file write strobe.
- `operation`: out, 2. ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND.
- `ram_write_enable`: out, 1. RAM write strobe (write of `data_out` at `addr_ram`).
- `halt`: out, 1. High while the CPU is stopped.

## Operation
- States:
  - BOOT: all outputs 0.
  - FETCH: `addr_sel`=0, `ir_enable`=1.
  - DECODE: `pc_enable`=1, `branch`=0.
  - LOAD_1: `addr_sel`=1, `c_sel`=1.
  - LOAD_2: `addr_sel`=1, `c_sel`=1, `white_reg_enable`=1.
  - STORE_1: `addr_sel`=1.
  - STORE_2: `addr_sel`=1, `ram_write_enable`=1.
  - MOVE: `operation`=00, `c_sel`=0, `white_reg_enable`=1.
  - ALU: `operation` from the instruction, `c_sel`=0, `white_reg_enable`=1.
  - BRANCH: `branch`=1, `pc_enable`=1.
  - HALT: `halt`=1, everything else 0.
- Any output not listed for a state is 0.
- Transitions:
  - BOOT→FETCH; FETCH→DECODE.
  - DECODE→ next state chosen by `decoded_instruction` (below).
  - LOAD_1→LOAD_2→FETCH; STORE_1→STORE_2→FETCH.
  - MOVE, ALU, BRANCH → FETCH.
  - HALT→HALT until reset.
- Decode map:
  - I_LOAD→LOAD_1; I_STORE→STORE_1; I_MOVE→MOVE.
  - I_ADD, I_SUB, I_AND, I_OR → ALU. The instruction is latched into a 2-bit op register in DECODE so `operation` is stable in ALU.
  - I_BRANCH→BRANCH (unconditional).
  - I_BZERO/I_BNZERO → BRANCH if `zero` is 1/0.
  - I_BNEG/I_BNNEG → BRANCH if `neg` is 1/0.
  - I_BOV/I_BNOV → BRANCH if `signed_overflow` is 1/0.
  - I_BUOV/I_BNUOV → BRANCH if `unsigned_overflow` is 1/0.
  - An untaken branch goes →FETCH.
  - I_HALT→HALT.
  - I_NOP and any unlisted code → FETCH.
- Flags are sampled only in DECODE. They are never sampled in the ALU state of the same instruction.
- The PC increments in DECODE. A taken branch therefore overwrites PC+1 in BRANCH.

## Timing
- While `rst_n` is low: state = BOOT and every output is 0 immediately, asynchronously.
- After `rst_n` deasserts, the first rising edge enters FETCH.
- Cycles per instruction:
  - NOP / untaken branch: 2.
  - MOVE / ALU / taken branch: 3.
  - LOAD / STORE: 4.
- RAM read is synchronous with one-cycle latency. `addr_sel`=1 is held in both LOAD states, so data is valid when LOAD_2 writes.
- `ram_write_enable` is high for exactly one cycle per STORE. The address has been stable for one prior cycle.
- Outputs are a pure function of the state register plus the op register; nothing is combinational from the inputs.
- Reset mid-instruction (any state) returns to BOOT within the same cycle. No partial write occurs after reset assertion.

## Structure
- `cpu_pkg` holds:
  - `decoded_instruction_type` (5-bit enum shared with the datapath);
  - `alu_op_t` constants;
  - `state_t` enum for the FSM.
- Single module: a state register, a next-state `always_comb`, and an output `always_comb`.
- No sub-module. The branch-condition mux is a function in `cpu_pkg`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → all outputs 0; first edge after release → FETCH, with `ir_enable`=1 and `addr_sel`=0.
- I_ADD decode → sequence FETCH, DECODE, ALU, with `operation`=01 and `white_reg_enable`=1 for exactly one cycle; I_SUB → 10.
- I_LOAD → `addr_sel`=1 for 2 cycles, `c_sel`=1 for 2 cycles, `white_reg_enable` only in the second. I_STORE → `ram_write_enable` pulses once, in the 4th cycle.
- I_BZERO with `zero`=1 → BRANCH with `branch`=1 and `pc_enable`=1; with `zero`=0 → back to FETCH after 2 cycles with `branch` never 1. Repeat for all 8 conditional codes.
- I_HALT → `halt`=1 held for 20 cycles with no enables active; `rst_n` pulse → BOOT then FETCH.
- Assert `rst_n`=0 during STORE_2 → `ram_write_enable` drops in the same cycle; the FSM restarts from BOOT.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU: decoded instruction codes,
// ALU operation codes, controller states and the branch-condition mux.
package cpu_pkg;

    // Decoded instruction produced by the datapath decoder.
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_BUOV   = 5'd15,
        I_BNUOV  = 5'd16,
        I_HALT   = 5'd17
    } decoded_instruction_type;

    // ALU operation select.
    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALU_OR  = 2'b00;
    localparam alu_op_t ALU_ADD = 2'b01;
    localparam alu_op_t ALU_SUB = 2'b10;
    localparam alu_op_t ALU_AND = 2'b11;

    // Controller states; encodings fixed so existing waveforms stay readable.
    typedef enum logic [3:0] {
        S_BOOT    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_LOAD_1  = 4'd3,
        S_LOAD_2  = 4'd4,
        S_STORE_1 = 4'd5,
        S_STORE_2 = 4'd6,
        S_MOVE    = 4'd7,
        S_ALU     = 4'd8,
        S_BRANCH  = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    // Branch condition: true when the instruction is a branch whose flag test holds.
    function automatic logic branch_taken(
        input logic [4:0] instr,
        input logic       zero,
        input logic       neg,
        input logic       unsigned_overflow,
        input logic       signed_overflow
    );
        logic taken;
        taken = 1'b0;
        case (instr)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero;
            I_BNZERO: taken = ~zero;
            I_BNEG:   taken = neg;
            I_BNNEG:  taken = ~neg;
            I_BOV:    taken = signed_overflow;
            I_BNOV:   taken = ~signed_overflow;
            I_BUOV:   taken = unsigned_overflow;
            I_BNUOV:  taken = ~unsigned_overflow;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

    // True for any instruction that is a (possibly conditional) branch.
    function automatic logic is_branch(input logic [4:0] instr);
        return (instr >= I_BRANCH) && (instr <= I_BNUOV);
    endfunction

    // ALU operation implied by an arithmetic/logic instruction.
    function automatic alu_op_t alu_op_of(input logic [4:0] instr);
        alu_op_t op;
        op = ALU_OR;
        case (instr)
            I_ADD:   op = ALU_ADD;
            I_SUB:   op = ALU_SUB;
            I_AND:   op = ALU_AND;
            I_OR:    op = ALU_OR;
            default: op = ALU_OR;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle Moore controller sequencing the CPU datapath.
// Outputs depend only on the state and op registers.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] decoded_instruction,
    input  logic       zero,
    input  logic       neg,
    input  logic       unsigned_overflow,
    input  logic       signed_overflow,
    output logic       branch,
    output logic       pc_enable,
    output logic       ir_enable,
    output logic       addr_sel,
    output logic       c_sel,
    output logic       white_reg_enable,
    output logic [1:0] operation,
    output logic       ram_write_enable,
    output logic       halt
);

    state_t  state_q, state_d;
    alu_op_t op_q, op_d;

    // State and latched ALU op registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            op_q    <= ALU_OR;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic; instruction and flags are only consulted in DECODE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_BOOT:    state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                op_d = alu_op_of(decoded_instruction);
                if (is_branch(decoded_instruction)) begin
                    state_d = branch_taken(decoded_instruction, zero, neg,
                                           unsigned_overflow, signed_overflow)
                              ? S_BRANCH : S_FETCH;
                end else begin
                    case (decoded_instruction)
                        I_LOAD:  state_d = S_LOAD_1;
                        I_STORE: state_d = S_STORE_1;
                        I_MOVE:  state_d = S_MOVE;
                        I_ADD,
                        I_SUB,
                        I_AND,
                        I_OR:    state_d = S_ALU;
                        I_HALT:  state_d = S_HALT;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_LOAD_1:  state_d = S_LOAD_2;
            S_LOAD_2:  state_d = S_FETCH;
            S_STORE_1: state_d = S_STORE_2;
            S_STORE_2: state_d = S_FETCH;
            S_MOVE:    state_d = S_FETCH;
            S_ALU:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_BOOT;
        endcase
    end

    // Moore output decode from the state register (ALU op from op register).
    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        white_reg_enable = 1'b0;
        operation        = ALU_OR;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_enable = 1'b1;
            end
            S_DECODE: begin
                pc_enable = 1'b1;
            end
            S_LOAD_1: begin
                addr_sel = 1'b1;
                c_sel    = 1'b1;
            end
            S_LOAD_2: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                white_reg_enable = 1'b1;
            end
            S_STORE_1: begin
                addr_sel = 1'b1;
            end
            S_STORE_2: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
            end
            S_MOVE: begin
                operation        = ALU_OR;
                white_reg_enable = 1'b1;
            end
            S_ALU: begin
                operation        = op_q;
                white_reg_enable = 1'b1;
            end
            S_BRANCH: begin
                branch    = 1'b1;
                pc_enable = 1'b1;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: begin
                halt = 1'b0;
            end
        endcase
    end

endmodule
